// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle unsigned multiply/divide unit for the RISC-V
// execute stage. One operation in flight, fixed latency of 32 iterations.
//
// Ports:
//   clk     rising-edge clock
//   rst_n   synchronous active-low reset
//   start   issue request, sampled only while idle
//   op      00 MUL (low word), 01 MULHU (high word), 10 DIVU, 11 REMU
//   x       operand A / dividend, sampled with start
//   y       operand B / divisor, sampled with start
//   busy    high from the cycle after accept through the done cycle
//   done    one-cycle pulse, result valid in that cycle
//   result  registered result, held until the next done
module muldiv_unit #(
    parameter int ITER = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    localparam int CW = $clog2(ITER);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OP_MUL   = 2'b00,
        OP_MULHU = 2'b01,
        OP_DIVU  = 2'b10,
        OP_REMU  = 2'b11
    } op_e;

    state_e          state_reg, state_next;
    logic [1:0]      op_reg;
    logic [31:0]     y_reg;
    // Multiply: full 64-bit product accumulator.
    // Divide: acc_reg[32:0] holds the partial remainder.
    logic [63:0]     acc_reg;
    // Multiply: multiplier, shifted right each iteration.
    // Divide: dividend shifted out of the MSB, quotient shifted into the LSB.
    logic [31:0]     lo_reg;
    logic [CW-1:0]   count_reg;
    logic [31:0]     result_reg;
    logic            busy_reg;
    logic            done_reg;

    logic            last_iter;

    // One shift-add multiply step.
    logic [32:0]     add_sum;
    logic [63:0]     mul_acc_next;
    logic [31:0]     mul_lo_next;

    // One restoring divide step.
    logic [32:0]     rem_shift;
    logic [32:0]     rem_diff;
    logic            rem_ge;
    logic [32:0]     rem_next;
    logic [31:0]     quo_next;

    logic [63:0]     acc_iter;
    logic [31:0]     lo_iter;
    logic [31:0]     result_next;

    assign last_iter = (count_reg == CW'(ITER - 1));

    always_comb begin
        // Carry out of the upper-half add is kept as bit 32 and shifted
        // back in as the new product MSB.
        add_sum      = {1'b0, acc_reg[63:32]} + (lo_reg[0] ? {1'b0, y_reg} : 33'd0);
        mul_acc_next = {add_sum, acc_reg[31:1]};
        mul_lo_next  = {1'b0, lo_reg[31:1]};

        rem_shift = {acc_reg[31:0], lo_reg[31]};
        rem_diff  = rem_shift - {1'b0, y_reg};
        rem_ge    = (rem_shift >= {1'b0, y_reg});
        rem_next  = rem_ge ? rem_diff : rem_shift;
        quo_next  = {lo_reg[30:0], rem_ge};

        if (op_reg[1]) begin
            acc_iter = {31'd0, rem_next};
            lo_iter  = quo_next;
        end else begin
            acc_iter = mul_acc_next;
            lo_iter  = mul_lo_next;
        end

        // Result is taken from the final iteration's combinational values so
        // that it can be registered on the same edge that enters DONE.
        unique case (op_e'(op_reg))
            OP_MUL:   result_next = mul_acc_next[31:0];
            OP_MULHU: result_next = mul_acc_next[63:32];
            OP_DIVU:  result_next = quo_next;
            OP_REMU:  result_next = rem_next[31:0];
            default:  result_next = 32'd0;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            S_IDLE:  if (start) state_next = S_RUN;
            S_RUN:   if (last_iter) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= S_IDLE;
            op_reg     <= 2'd0;
            y_reg      <= 32'd0;
            acc_reg    <= 64'd0;
            lo_reg     <= 32'd0;
            count_reg  <= '0;
            result_reg <= 32'd0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            busy_reg  <= (state_next != S_IDLE);
            done_reg  <= (state_next == S_DONE);
            unique case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        op_reg    <= op;
                        y_reg     <= y;
                        acc_reg   <= 64'd0;
                        lo_reg    <= x;
                        count_reg <= '0;
                    end
                end
                S_RUN: begin
                    acc_reg   <= acc_iter;
                    lo_reg    <= lo_iter;
                    count_reg <= count_reg + 1'b1;
                    if (last_iter) begin
                        result_reg <= result_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy   = busy_reg;
    assign done   = done_reg;
    assign result = result_reg;

endmodule
